// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add sequencer.
// Takes an operand pair over a valid/ready handshake. It runs one 1-bit
// full-add slice per cycle, LSB first, for WIDTH cycles. It then presents
// the WIDTH-bit sum and the carry-out over a second valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand pair present
//   in_ready   block can accept operands (IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   out_valid  result available (DONE)
//   out_ready  consumer takes result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   busy       high in RUN or DONE
//   ovfl       signed overflow flag (only with SERIAL_ADD_OVFL_EN defined)
//
// Optional feature macro: SERIAL_ADD_OVFL_EN
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADD_OVFL_EN
    ,
    output logic             ovfl
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             carry_q, carry_n;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
    logic [WIDTH-1:0] sum_n;
    logic             cout_n, in_ready_n, out_valid_n, busy_n;
    logic             hs1, hc1, hc2, s_bit, c_bit;
`ifdef SERIAL_ADD_OVFL_EN
    logic             ovfl_n;
`endif

    // One full-add slice built from two half adders and an OR.
    always_comb begin : slice
        hs1   = a_q[0] ^ b_q[0];
        hc1   = a_q[0] & b_q[0];
        s_bit = hs1 ^ carry_q;
        hc2   = hs1 & carry_q;
        c_bit = hc1 | hc2;
    end

    // Next-state and next-output logic.
    always_comb begin : next_logic
        state_n     = state_q;
        cnt_n       = cnt_q;
        carry_n     = carry_q;
        a_n         = a_q;
        b_n         = b_q;
        sum_n       = sum;
        cout_n      = cout;
        in_ready_n  = in_ready;
        out_valid_n = out_valid;
        busy_n      = busy;
`ifdef SERIAL_ADD_OVFL_EN
        ovfl_n      = ovfl;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_n        = a;
                    b_n        = b;
                    carry_n    = cin;
                    cnt_n      = '0;
                    state_n    = RUN;
                    in_ready_n = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            RUN: begin
                a_n     = a_q >> 1;
                b_n     = b_q >> 1;
                sum_n   = {s_bit, sum[WIDTH-1:1]};
                carry_n = c_bit;
                // Exit is tested before increment, so the counter never wraps.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_n     = DONE;
                    cout_n      = c_bit;
                    out_valid_n = 1'b1;
`ifdef SERIAL_ADD_OVFL_EN
                    // carry_q is the carry into the MSB on this last slice.
                    ovfl_n      = carry_q ^ c_bit;
`endif
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b0;
                    busy_n      = 1'b0;
                    in_ready_n  = 1'b1;
                end
            end
            default: begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
                busy_n      = 1'b0;
                in_ready_n  = 1'b1;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin : regs
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SERIAL_ADD_OVFL_EN
            ovfl      <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            carry_q   <= carry_n;
            a_q       <= a_n;
            b_q       <= b_n;
            sum       <= sum_n;
            cout      <= cout_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
`ifdef SERIAL_ADD_OVFL_EN
            ovfl      <= ovfl_n;
`endif
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl.
// Expected results come from plain arithmetic on the accepted operands.
// They are queued at acceptance and compared by a monitor whenever the
// DUT presents out_valid.
module tb_serial_add_ctrl;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, cin_s, out_valid, out_ready, cout, busy;
    logic [W-1:0] in_a, in_b, sum;
`ifdef SERIAL_ADD_OVFL_EN
    logic         ovfl;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit b2b_mode = 1'b0;
    bit prev_ov  = 1'b0;
    int last_acc = -1;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           t;
    } exp_t;

    exp_t exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (in_a),
        .b         (in_b),
        .cin       (cin_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADD_OVFL_EN
        ,
        .ovfl      (ovfl)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 60000) begin
            $display("FAIL watchdog: cycle budget exhausted, errors so far %0d", errors);
            $fatal(1, "watchdog");
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: unsigned (W+1)-bit sum, plus signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input int t);
        exp_t        e;
        logic [W:0]  full;
        longint      st;
        longint      lim;
        full = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
        e.s  = full[W-1:0];
        e.c  = full[W];
        st   = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        lim  = longint'(1) << (W - 1);
        e.o  = (st > lim - 1) || (st < -lim);
        e.t  = t;
        return e;
    endfunction

    // Monitor: captures accepted operands and checks every presented result.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_ov  = 1'b0;
            last_acc = -1;
        end else begin
            chk("ready_valid_exclusive", 64'(in_ready & out_valid), 64'(0));
            if (out_valid) begin
                chk("result_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    if (!prev_ov)
                        chk("latency", 64'(cyc), 64'(exp_q[0].t + int'(W)));
                    chk("sum", 64'(sum), 64'(exp_q[0].s));
                    chk("cout", 64'(cout), 64'(exp_q[0].c));
`ifdef SERIAL_ADD_OVFL_EN
                    chk("ovfl", 64'(ovfl), 64'(exp_q[0].o));
`endif
                    chk("busy_done", 64'(busy), 64'(1));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                if (b2b_mode && last_acc >= 0)
                    chk("b2b_interval", 64'(cyc + 1 - last_acc), 64'(W + 2));
                last_acc = cyc + 1;
                exp_q.push_back(model(in_a, in_b, cin_s, cyc + 1));
            end
            if (!b2b_mode) last_acc = -1;
            prev_ov = out_valid;
        end
    end

    // One operand pair with backpressure and ignored in_valid toggling.
    task automatic directed(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                            input logic [W-1:0] es, input logic ec, input logic eo,
                            input int hold);
        int n;
        @(posedge clk); #1;
        in_a = ta; in_b = tbv; cin_s = tc; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 4 * int'(W)) begin
            @(posedge clk); #1; n++;
        end
        chk("dir_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        n = 0;
        while (!out_valid && n < 2 * int'(W)) begin
            in_valid = ~in_valid; in_a = W'(16'h1234); in_b = W'(16'h1234);
            @(posedge clk); #1; n++;
        end
        chk("dir_latency", 64'(n), 64'(W));
        for (int i = 0; i < hold; i++) begin
            chk("bp_sum", 64'(sum), 64'(es));
            chk("bp_cout", 64'(cout), 64'(ec));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_busy", 64'(busy), 64'(1));
            chk("bp_valid", 64'(out_valid), 64'(1));
            in_valid = ~in_valid; in_a = W'(16'h1234);
            @(posedge clk); #1;
        end
        chk("dir_sum", 64'(sum), 64'(es));
        chk("dir_cout", 64'(cout), 64'(ec));
`ifdef SERIAL_ADD_OVFL_EN
        chk("dir_ovfl", 64'(ovfl), 64'(eo));
`else
        if (eo === 1'bx) chk("dir_eo_known", 64'(eo), 64'(0));
`endif
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_in_ready", 64'(in_ready), 64'(1));
        chk("hs_valid_drop", 64'(out_valid), 64'(0));
        chk("hs_busy_drop", 64'(busy), 64'(0));
        chk("hs_sum_kept", 64'(sum), 64'(es));
        chk("hs_cout_kept", 64'(cout), 64'(ec));
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int n_ov;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; cin_s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        reset = 1'b0;

        directed(W'(16'h0001), W'(16'h0001), 1'b0, W'(16'h0002), 1'b0, 1'b0, 0);
        directed(W'(16'hFFFF), W'(16'h0001), 1'b0, W'(16'h0000), 1'b1, 1'b0, 0);
        directed(W'(16'hFFFF), W'(16'hFFFF), 1'b1, W'(16'hFFFF), 1'b1, 1'b0, 5);
        directed(W'(16'h7FFF), W'(16'h0001), 1'b0, W'(16'h8000), 1'b0, 1'b1, 2);
        directed(W'(16'h8000), W'(16'h8000), 1'b0, W'(16'h0000), 1'b1, 1'b1, 0);

        // Reset in the middle of RUN discards the pending result.
        @(posedge clk); #1;
        in_a = W'($urandom); in_b = W'($urandom); cin_s = 1'b1; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 4 * int'(W)) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_sum", 64'(sum), 64'(0));
        chk("midrst_cout", 64'(cout), 64'(0));
        reset = 1'b0; out_ready = 1'b1;
        n_ov = 0;
        for (int i = 0; i < 2 * int'(W); i++) begin
            @(posedge clk); #1;
            if (out_valid) n_ov++;
        end
        chk("no_stale_valid", 64'(n_ov), 64'(0));

        // Randomized traffic with random backpressure and rare resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset     = ($urandom_range(0, 299) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            cin_s     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) in_a = '1;
            if ($urandom_range(0, 7) == 0) in_b = W'(1) << (W - 1);
        end

        // Back-to-back: in_valid and out_ready held high.
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2 * W) @(posedge clk);
        #1;
        b2b_mode = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 6 * int'(W + 2); i++) begin
            in_a = W'($urandom); in_b = W'($urandom); cin_s = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; b2b_mode = 1'b0;
        repeat (2 * W + 4) @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
